// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state type and line sizing for the data-cache miss sequencer
package dmem_pkg;
   typedef enum logic [1:0] {IDLE, WB, FILL, DONE} miss_state_t;
   localparam int LINE_WORDS  = 4;
   localparam int WORD_BITS   = $clog2(LINE_WORDS);
   localparam int OFFSET_BITS = WORD_BITS + 2;
endpackage

// File: rtl/dmem_miss_sequencer.sv
// dmem_miss_sequencer: services lane-0 then lane-1 data-cache misses (writeback, refill, tag install) over one memory word port
module dmem_miss_sequencer #(
   parameter int LINE_WORDS = dmem_pkg::LINE_WORDS,
   parameter int ADDR_W     = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          memread0_mem,
   input  logic                          memwrite0_mem,
   input  logic                          memread1_mem,
   input  logic                          memwrite1_mem,
   input  logic [ADDR_W-1:0]             addr0_mem,
   input  logic [ADDR_W-1:0]             addr1_mem,
   input  logic                          cache_hit0_mem,
   input  logic                          cache_hit1_mem,
   input  logic                          valid_dirty0_mem,
   input  logic                          valid_dirty1_mem,
   input  logic [ADDR_W-1:0]             victim_addr0_mem,
   input  logic [ADDR_W-1:0]             victim_addr1_mem,
   input  logic [31:0]                   cache_rdata,
   input  logic                          mem_ready,
   input  logic [31:0]                   mem_rdata,
   output logic                          stall_latch_mem,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [31:0]                   mem_wdata,
   output logic                          cache_lane,
   output logic [$clog2(LINE_WORDS)-1:0] cache_word,
   output logic                          cache_fill_we,
   output logic                          cache_fill_done,
   output logic [31:0]                   miss_count
);
   import dmem_pkg::*;
   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
   miss_state_t state, state_nx;
   logic [BEAT_W-1:0] beat;
   logic [ADDR_W-1:0] miss_base, victim_base;
   logic lane, need0, need1, sel, beat_last, unused_ok;
   assign need0     = (memread0_mem | memwrite0_mem) & ~cache_hit0_mem;
   assign need1     = (memread1_mem | memwrite1_mem) & ~cache_hit1_mem;
   assign sel       = ~need0;
   assign beat_last = mem_ready && (beat == BEAT_W'(LINE_WORDS - 1));
   // refill data goes straight from memory into the cache array
   assign unused_ok = ^mem_rdata;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (need0 | need1) state_nx = (sel ? valid_dirty1_mem : valid_dirty0_mem) ? WB : FILL;
         WB:      if (beat_last) state_nx = FILL;
         FILL:    if (beat_last) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end
   // beat wraps to zero after the last word, so WB hands FILL a cleared counter
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         beat        <= '0;
         lane        <= 1'b0;
         miss_base   <= '0;
         victim_base <= '0;
         miss_count  <= '0;
      end else begin
         if (state == IDLE && (need0 | need1)) begin
            lane        <= sel;
            miss_base   <= (sel ? addr1_mem : addr0_mem) & ~OFF_MASK;
            victim_base <= sel ? victim_addr1_mem : victim_addr0_mem;
            beat        <= '0;
         end
         if ((state == WB || state == FILL) && mem_ready) beat <= beat + 1'b1;
         if (state == DONE) miss_count <= miss_count + 32'd1;
      end
   always_comb begin
      stall_latch_mem = (state == IDLE) ? (need0 | need1) : 1'b1;
      mem_req         = (state == WB) || (state == FILL);
      mem_we          = state == WB;
      mem_addr        = ((state == WB) ? victim_base : miss_base) + {{(ADDR_W-BEAT_W-2){1'b0}}, beat, 2'b00};
      cache_fill_we   = (state == FILL) && mem_ready;
      cache_fill_done = state == DONE;
   end
   assign mem_wdata  = cache_rdata;
   assign cache_lane = lane;
   assign cache_word = beat;
endmodule

// File: doc/dmem_miss_sequencer.md
# dmem_miss_sequencer

Sequences data-cache misses for both issue lanes of the dual-issue pipeline over the single shared main-memory word port. On a miss it writes back a dirty victim line if needed, then refills the missing line. Lane 0 is serviced before lane 1. While any miss is pending or in service it drives `stall_latch_mem`, which freezes IF through MEM and flushes WB in the hazard detector.

## Interface
Parameters:
- `LINE_WORDS`, 4 — 32-bit words per cache line; power of two, at least 2.
- `ADDR_W`, 32 — byte address width.

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `reset` in 1 — asynchronous, active-high.
- `memread0_mem`, `memwrite0_mem`, `memread1_mem`, `memwrite1_mem` in 1 — MEM-stage access strobes, one pair per lane.
- `addr0_mem`, `addr1_mem` in ADDR_W — MEM-stage byte addresses.
- `cache_hit0_mem`, `cache_hit1_mem` in 1 — tag lookup result per lane.
- `valid_dirty0_mem`, `valid_dirty1_mem` in 1 — the indexed victim line is valid and dirty.
- `victim_addr0_mem`, `victim_addr1_mem` in ADDR_W — line base address of the victim.
- `cache_rdata` in 32 — combinational cache read data for (`cache_lane`, `cache_word`).
- `mem_ready` in 1 — one-cycle acknowledge of the current word request.
- `mem_rdata` in 32 — read data, valid when `mem_ready` is high during a read.
- `stall_latch_mem` out 1 — miss stall to the hazard detector.
- `mem_req` out 1 — word request; held high until acknowledged.
- `mem_we` out 1 — 1 for write (writeback), 0 for read (refill).
- `mem_addr` out ADDR_W — word-aligned address of the current beat.
- `mem_wdata` out 32 — equals `cache_rdata`.
- `cache_lane` out 1 — lane whose set is being serviced.
- `cache_word` out log2(LINE_WORDS) — current beat index.
- `cache_fill_we` out 1 — write `mem_rdata` into word `cache_word` of the serviced line.
- `cache_fill_done` out 1 — one-cycle pulse: install tag, set valid, clear dirty.
- `miss_count` out 32 — number of completed refills; wraps modulo 2^32.

## Operation
- `need_k` = (`memread_k` | `memwrite_k`) & ~`cache_hit_k`.
- States:
  - IDLE: no miss in service.
  - WB: writing back the victim line.
  - FILL: refilling the missing line.
  - DONE: one-cycle tag install.
- IDLE behaviour:
  - `stall_latch_mem` = `need0` | `need1` (combinational).
  - On the edge, select lane 0 if `need0`, else lane 1; latch the lane, the miss line base (`addr` with offset bits cleared) and `victim_addr`.
  - Go to WB if that lane's `valid_dirty` is set, else to FILL. Clear the beat counter.
- WB behaviour:
  - `mem_req`=1, `mem_we`=1, `mem_addr` = victim base + 4*beat.
  - On `mem_ready`: increment beat. After beat LINE_WORDS-1, clear beat and go to FILL.
- FILL behaviour:
  - `mem_req`=1, `mem_we`=0, `mem_addr` = miss base + 4*beat.
  - `cache_fill_we` = `mem_ready` (combinational).
  - After the last beat, go to DONE.
- DONE behaviour: `cache_fill_done`=1, `miss_count` increments, next state IDLE.
- In WB, FILL and DONE, `stall_latch_mem`=1.
- The pipeline is frozen during service, so MEM-stage inputs are stable.
- After DONE, IDLE re-evaluates both lanes:
  - The serviced lane now hits.
  - A pending lane-1 miss is serviced next.
  - If lane 1 missed on the same line, it now hits and is not refetched.
- `mem_ready` outside WB/FILL is ignored.
- `cache_fill_we` and `cache_fill_done` are never high together.

## Timing
- Reset values:
  - State IDLE, beat 0, `miss_count` 0.
  - `mem_req`, `mem_we`, `cache_fill_we`, `cache_fill_done` all 0.
  - `stall_latch_mem` follows the IDLE equation.
- Clean miss detected in cycle t:
  - Stall is high in t.
  - First `mem_req` in t+1.
  - Last ready in cycle c gives DONE in c+1; IDLE in c+2, with stall low if no other miss.
- Dirty miss: WB beats precede FILL, and the first FILL request follows the cycle after the last WB ready.
- With fixed memory latency L per beat, a clean miss stalls LINE_WORDS*L + 2 cycles. A dirty miss stalls 2*LINE_WORDS*L + 2 cycles.
- Beat address changes the cycle after `mem_ready`; `mem_req` stays high across beats.
- Reset asserted mid-WB/FILL:
  - Immediately go to IDLE and drop `mem_req`.
  - Do not pulse `cache_fill_done`.
  - The memory model shares `reset`.

## Structure
- Shared package `dmem_pkg` holds:
  - the state enum (IDLE, WB, FILL, DONE);
  - the `LINE_WORDS` default;
  - `WORD_BITS` = log2(LINE_WORDS);
  - `OFFSET_BITS` = WORD_BITS + 2.
- No sub-module; the beat counter is inline.

## Test plan
- Lane-0 clean read miss at 0x100, LINE_WORDS=4, L=3:
  - addresses 0x100, 0x104, 0x108, 0x10C; four `cache_fill_we` pulses;
  - `cache_fill_done` once; stall 14 cycles; `miss_count`=1.
- Lane-1 dirty write miss, victim 0x2000, miss 0x300:
  - four writes to 0x2000–0x200C with `mem_we`=1, then four reads from 0x300–0x30C;
  - stall 26 cycles.
- Both lanes miss in the same cycle, lines 0x400 and 0x800: lane 0 filled first (`cache_lane`=0), then lane 1; `miss_count`=2.
- Both lanes miss the same line 0x500: a single refill; lane 1 hits afterwards; `miss_count`=1.
- Hit on both lanes, or no access: `stall_latch_mem`=0, `mem_req` never asserted.
- Reset pulse during FILL beat 2:
  - `mem_req`=0 and state IDLE at once;
  - no `cache_fill_done`; `miss_count`=0;
  - the miss restarts from beat 0 after reset.
